// File: rtl/relu_stream_sched_if.sv
// Memory-side bus of the shared ReLU lane: one read port, one write port.
// The scheduler drives the master side; feature memory is the slave side.
interface relu_stream_sched_if #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 16
);
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [16*LANES-1:0]   rd_data;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [16*LANES-1:0]   wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data
   );
endinterface

// File: rtl/relu_stream_sched.sv
// relu_stream_sched: round-robin two-requester sequencer for the ReLU lane.
// Define RELU_NEGCOUNT_EN to add the per-job neg_count counter and port.
module relu_stream_sched #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        start,
   input  logic [ADDR_W-1:0] src0,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] dst0,
   input  logic [ADDR_W-1:0] dst1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   output logic [1:0]        pending,
   output logic [1:0]        grant,
   output logic [1:0]        done,
   output logic              busy,
`ifdef RELU_NEGCOUNT_EN
   output logic [31:0]       neg_count,
`endif
   relu_stream_sched_if.master mem
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   localparam int DW = 16 * LANES;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q [2], src_d [2];
   logic [ADDR_W-1:0] dst_q [2], dst_d [2];
   logic [LEN_W-1:0]  len_q [2], len_d [2];
   logic [1:0]        pending_q, pending_d;
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        done_q, done_d;
   logic              rr_q, rr_d;
   logic              own_q, own_d;
   logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic              rd_v_q, rd_v_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0]     wr_data_q, wr_data_d;
   logic              rd_en_c, sel, grab;
`ifdef RELU_NEGCOUNT_EN
   logic [7:0]        negl_q, negl_d;
   logic [31:0]       neg_count_q, neg_count_d;
   logic [32:0]       nsum;
`endif

   // Descriptor capture, arbitration, job sequencing and ReLU datapath.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      pending_d = pending_q;
      grant_d   = grant_q;
      done_d    = '0;
      rr_d      = rr_q;
      own_d     = own_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      rd_v_d    = 1'b0;
      wr_en_d   = rd_v_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_en_c   = 1'b0;
      sel       = 1'b0;
      grab      = 1'b0;
      if (start[0] && !pending_q[0] && !grant_q[0]) begin
         src_d[0]     = src0;
         dst_d[0]     = dst0;
         len_d[0]     = len0;
         pending_d[0] = 1'b1;
      end
      if (start[1] && !pending_q[1] && !grant_q[1]) begin
         src_d[1]     = src1;
         dst_d[1]     = dst1;
         len_d[1]     = len1;
         pending_d[1] = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (|pending_q) begin
               sel            = (&pending_q) ? rr_q : pending_q[1];
               grab           = 1'b1;
               pending_d[sel] = 1'b0;
               grant_d        = sel ? 2'b10 : 2'b01;
               own_d          = sel;
               rr_d           = ~sel;
               state_d        = RUN;
            end
         end
         RUN: begin
            if (len_q[own_q] == '0) begin
               state_d        = DONE;
               grant_d        = '0;
               done_d[own_q]  = 1'b1;
            end else begin
               rd_en_c  = 1'b1;
               rd_v_d   = 1'b1;
               rd_cnt_d = rd_cnt_q + LEN_W'(1);
               if (rd_cnt_q == len_q[own_q] - LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (wr_en_q && !rd_v_q) begin
               state_d        = DONE;
               grant_d        = '0;
               done_d[own_q]  = 1'b1;
            end
         end
         DONE: state_d = IDLE;
      endcase
      if (grab) begin
         rd_cnt_d = '0;
         wr_cnt_d = '0;
      end
      if (rd_v_q) begin
         wr_addr_d = dst_q[own_q] + ADDR_W'(wr_cnt_q);
         wr_cnt_d  = wr_cnt_q + LEN_W'(1);
         for (int l = 0; l < LANES; l++)
            wr_data_d[16*l +: 16] = mem.rd_data[16*l+15] ? 16'h0000
                                                          : mem.rd_data[16*l +: 16];
      end
   end

`ifdef RELU_NEGCOUNT_EN
   // Per-job count of zeroed lanes, added as each word is written.
   always_comb begin
      negl_d      = negl_q;
      neg_count_d = neg_count_q;
      nsum        = {1'b0, neg_count_q} + 33'(negl_q);
      if (rd_v_q) begin
         negl_d = '0;
         for (int l = 0; l < LANES; l++)
            if (mem.rd_data[16*l+15]) negl_d = negl_d + 8'd1;
      end
      if (grab) neg_count_d = '0;
      else if (wr_en_q) neg_count_d = nsum[32] ? '1 : nsum[31:0];
   end
`endif

   // State register with synchronous reset; aborts any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         src_q       <= '{default: '0};
         dst_q       <= '{default: '0};
         len_q       <= '{default: '0};
         pending_q   <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         rr_q        <= 1'b0;
         own_q       <= 1'b0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         rd_v_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
`ifdef RELU_NEGCOUNT_EN
         negl_q      <= '0;
         neg_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         pending_q   <= pending_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         rr_q        <= rr_d;
         own_q       <= own_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_v_q      <= rd_v_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
`ifdef RELU_NEGCOUNT_EN
         negl_q      <= negl_d;
         neg_count_q <= neg_count_d;
`endif
      end
   end

   assign pending     = pending_q;
   assign grant       = grant_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);
   assign mem.rd_en   = rd_en_c;
   assign mem.rd_addr = rd_en_c ? src_q[own_q] + ADDR_W'(rd_cnt_q) : '0;
   assign mem.wr_en   = wr_en_q;
   assign mem.wr_addr = wr_addr_q;
   assign mem.wr_data = wr_data_q;
`ifdef RELU_NEGCOUNT_EN
   assign neg_count   = neg_count_q;
`endif
endmodule
